// File: rtl/register_file_if.sv
// Write-back / register-read bundle between the pipeline and the register file.
// The master side (pipeline) drives the write-back triple and the read indices;
// the slave side (register file) returns read data and the commit counter.
interface register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WB_RegDest;
    logic [DATA_W-1:0] WB_WriteReg;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgAddr;
    logic [DATA_W-1:0] DbgData;
    logic [31:0]       WriteCount;

    modport master (
        output RegWrite, WB_RegDest, WB_WriteReg, ReadReg1, ReadReg2, DbgAddr,
        input  ReadData1, ReadData2, DbgData, WriteCount
    );

    modport slave (
        input  RegWrite, WB_RegDest, WB_WriteReg, ReadReg1, ReadReg2, DbgAddr,
        output ReadData1, ReadData2, DbgData, WriteCount
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file: one write-back port, two combinational ID read
// ports with optional same-cycle write-to-read bypass, a never-bypassed debug
// read port and a free-running count of committed writes.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic clk,
    input  logic reset,
    register_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [31:0]       write_count;
    logic              commit;
    logic              bypass_live;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] dbg_data;

    // Register 0 is hardwired to zero, so a write aimed at it is not a commit.
    assign commit      = bus.RegWrite && (bus.WB_RegDest != '0);
    // Bypass only forwards a write that will actually land at the next edge.
    assign bypass_live = (BYPASS != 0) && commit && !reset;

    // Resolve one ID read port: r0 and reset force zero, then bypass, then storage.
    function automatic logic [DATA_W-1:0] resolve_read(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_idx,
        input logic [DATA_W-1:0] fwd_data,
        input logic              in_reset
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (fwd_en && (idx == fwd_idx))
            value = fwd_data;
        if (in_reset || (idx == '0))
            value = '0;
        return value;
    endfunction

    // Storage update: asynchronous clear, otherwise commit one write per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[bus.WB_RegDest] <= bus.WB_WriteReg;
        end
    end

    // Committed-write counter; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            write_count <= '0;
        else if (commit)
            write_count <= write_count + 32'd1;
    end

    // Combinational read ports; the debug port always shows committed state.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        dbg_data   = '0;
        read_data1 = resolve_read(bus.ReadReg1, regs[bus.ReadReg1], bypass_live,
                                  bus.WB_RegDest, bus.WB_WriteReg, reset);
        read_data2 = resolve_read(bus.ReadReg2, regs[bus.ReadReg2], bypass_live,
                                  bus.WB_RegDest, bus.WB_WriteReg, reset);
        dbg_data   = resolve_read(bus.DbgAddr, regs[bus.DbgAddr], 1'b0,
                                  bus.WB_RegDest, bus.WB_WriteReg, reset);
    end

    assign bus.ReadData1  = read_data1;
    assign bus.ReadData2  = read_data2;
    assign bus.DbgData    = dbg_data;
    assign bus.WriteCount = write_count;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a bypassing and a non-bypassing instance share the
// same stimulus; expected outputs are queued as stimulus is applied and popped
// against the DUT outputs once the combinational paths have settled.
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] wdata;
    logic [4:0]  rr1, rr2, dbg;

    int checks = 0;
    int failures = 0;

    // Reference model of committed state
    logic [31:0] model [32];
    logic [31:0] model_cnt;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    register_file_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    register_file_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

    assign ifa.RegWrite = reg_write;  assign ifb.RegWrite = reg_write;
    assign ifa.WB_RegDest = dest;     assign ifb.WB_RegDest = dest;
    assign ifa.WB_WriteReg = wdata;   assign ifb.WB_WriteReg = wdata;
    assign ifa.ReadReg1 = rr1;        assign ifb.ReadReg1 = rr1;
    assign ifa.ReadReg2 = rr2;        assign ifb.ReadReg2 = rr2;
    assign ifa.DbgAddr = dbg;         assign ifb.DbgAddr = dbg;

    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    register_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return ifa.ReadData1;
            1: return ifa.ReadData2;
            2: return ifa.DbgData;
            3: return ifa.WriteCount;
            4: return ifb.ReadData1;
            5: return ifb.ReadData2;
            6: return ifb.DbgData;
            default: return ifb.WriteCount;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit byp);
        if (reset || idx == 5'd0) return 32'h0;
        if (byp && reg_write && dest != 5'd0 && idx == dest) return wdata;
        return model[idx];
    endfunction

    task automatic expect_lit(input string tag, input int sel, input logic [31:0] v);
        sb_q.push_back('{tag, sel, v});
    endtask

    task automatic push_all(input string tag);
        expect_lit($sformatf("%s.a_rd1", tag), 0, exp_read(rr1, 1'b1));
        expect_lit($sformatf("%s.a_rd2", tag), 1, exp_read(rr2, 1'b1));
        expect_lit($sformatf("%s.a_dbg", tag), 2, exp_read(dbg, 1'b0));
        expect_lit($sformatf("%s.a_cnt", tag), 3, reset ? 32'h0 : model_cnt);
        expect_lit($sformatf("%s.b_rd1", tag), 4, exp_read(rr1, 1'b0));
        expect_lit($sformatf("%s.b_rd2", tag), 5, exp_read(rr2, 1'b0));
        expect_lit($sformatf("%s.b_dbg", tag), 6, exp_read(dbg, 1'b0));
        expect_lit($sformatf("%s.b_cnt", tag), 7, reset ? 32'h0 : model_cnt);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model_cnt = 32'h0;
    endtask

    // Compare now, with no clock edge involved
    task automatic check_now(input string tag);
        push_all(tag);
        #1;
        drain();
    endtask

    // Compare mid-cycle, then cross one rising edge and update the model
    task automatic do_cycle(input string tag);
        push_all(tag);
        @(negedge clk);
        drain();
        @(posedge clk);
        if (!reset && reg_write && dest != 5'd0) begin
            model[dest] = wdata;
            model_cnt = model_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic set_in(input logic we, input logic [4:0] d, input logic [31:0] w,
                          input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        reg_write = we; dest = d; wdata = w; rr1 = a1; rr2 = a2; dbg = ad;
    endtask

    initial begin
        reset = 1'b1;
        model_clear();
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #2;
        check_now("reset_init");
        @(posedge clk); #1;
        reset = 1'b0;

        // Asynchronous reset clears stored data without a clock
        set_in(1'b1, 5'd5, 32'h12345678, 5'd0, 5'd0, 5'd0);
        do_cycle("load_r5");
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check_now("r5_loaded");
        #2;
        reset = 1'b1;
        model_clear();
        expect_lit("async_rst_rd1", 0, 32'h0);
        expect_lit("async_rst_dbg", 2, 32'h0);
        expect_lit("async_rst_cnt", 3, 32'h0);
        check_now("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic write then read on both ports
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 5'd5);
        do_cycle("wr_r5");
        set_in(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        expect_lit("basic_rd1", 0, 32'hDEADBEEF);
        expect_lit("basic_rd2", 1, 32'hDEADBEEF);
        expect_lit("basic_cnt", 3, 32'd1);
        do_cycle("rd_r5");

        // r0 is never written and never counted
        set_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        expect_lit("r0_same_rd1", 0, 32'h0);
        do_cycle("wr_r0");
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_lit("r0_next_rd1", 0, 32'h0);
        expect_lit("r0_next_cnt", 3, 32'd1);
        do_cycle("rd_r0");

        // Bypass versus stored reads
        set_in(1'b1, 5'd7, 32'h00000001, 5'd0, 5'd0, 5'd0);
        do_cycle("wr_r7_init");
        set_in(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7);
        expect_lit("byp_a_rd1", 0, 32'hCAFEF00D);
        expect_lit("byp_a_rd2", 1, 32'hCAFEF00D);
        expect_lit("byp_a_dbg", 2, 32'h00000001);
        expect_lit("nobyp_b_rd1", 4, 32'h00000001);
        expect_lit("nobyp_b_rd2", 5, 32'h00000001);
        do_cycle("byp_r7");
        set_in(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        expect_lit("after_a_dbg", 2, 32'hCAFEF00D);
        expect_lit("after_b_rd1", 4, 32'hCAFEF00D);
        do_cycle("after_r7");
        set_in(1'b1, 5'd7, 32'h0BADF00D, 5'd7, 5'd5, 5'd5);
        expect_lit("byp_split_rd1", 0, 32'h0BADF00D);
        expect_lit("byp_split_rd2", 1, 32'hDEADBEEF);
        do_cycle("byp_split");

        // A write held across an edge under reset is dropped
        set_in(1'b1, 5'd9, 32'hAAAA5555, 5'd9, 5'd9, 5'd9);
        reset = 1'b1;
        model_clear();
        expect_lit("rst_wr_byp_sup", 0, 32'h0);
        do_cycle("rst_wr");
        #2;
        reset = 1'b0;
        set_in(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_lit("rst_wr_r9", 0, 32'h0);
        expect_lit("rst_wr_cnt", 3, 32'h0);
        check_now("rst_wr_rel");
        @(posedge clk); #1;

        // Randomised traffic against the model, biased toward read/write collisions
        for (int n = 0; n < 150; n++) begin
            logic [4:0] d;
            d = 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 1)), d, $urandom(),
                   ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31)));
            do_cycle($sformatf("rand%0d", n));
        end

        // Counter wrap from a preloaded all-ones value
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        force dut.write_count = 32'hFFFFFFFF;
        force dut_nb.write_count = 32'hFFFFFFFF;
        #1;
        release dut.write_count;
        release dut_nb.write_count;
        model_cnt = 32'hFFFFFFFF;
        check_now("preload");
        set_in(1'b1, 5'd3, 32'h13572468, 5'd3, 5'd0, 5'd3);
        do_cycle("wrap_wr");
        set_in(1'b1, 5'd0, 32'h5A5A5A5A, 5'd3, 5'd0, 5'd3);
        expect_lit("wrap_cnt", 3, 32'h0);
        expect_lit("wrap_r3", 0, 32'h13572468);
        do_cycle("wrap_r0_wr");
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        expect_lit("wrap_r0_cnt", 3, 32'h0);
        do_cycle("wrap_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
